// File: rtl/fetch_seq_unit.sv
// fetch_seq_unit
//   PC sequencer, IF/ID pipeline register and circular return-address stack.
//   Sits between inst_mem (IF) and control/reg_file (ID).
//
// Ports
//   clk             rising-edge clock
//   reset           asynchronous active-low reset
//   stall           load-use hold: freezes PC and IF/ID, no redirect, no RAS op
//   id_branch       taken branch resolved in ID
//   id_jump         unconditional jump in ID
//   id_call         call in ID (jump to id_target, push id_pc_plus_one)
//   id_ret          return in ID (jump to RAS top, pop)
//   id_target       branch/jump/call target
//   if_instruction  instruction fetched at pc
//   pc              fetch address
//   id_instruction  registered instruction for ID (0 on bubble)
//   id_pc_plus_one  registered pc+1 for ID (0 on bubble)
//   id_valid        ID holds a real instruction
//   flush           combinational: redirect taken this cycle
//   ras_count       live RAS entries, saturates at RAS_DEPTH
//   ras_overflow    sticky: push while full
//   ras_underflow   sticky: pop while empty
//
// Optional build macro FETCH_SEQ_PERF_EN adds perf_stall_cnt / perf_flush_cnt
// (free-running 32-bit counters of stall cycles and flush cycles).

module fetch_seq_unit #(
  parameter int              PC_W      = 8,
  parameter int              INST_W    = 19,
  parameter int              RAS_DEPTH = 8,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic                           id_branch,
  input  logic                           id_jump,
  input  logic                           id_call,
  input  logic                           id_ret,
  input  logic [PC_W-1:0]                id_target,
  input  logic [INST_W-1:0]              if_instruction,
  output logic [PC_W-1:0]                pc,
  output logic [INST_W-1:0]              id_instruction,
  output logic [PC_W-1:0]                id_pc_plus_one,
  output logic                           id_valid,
  output logic                           flush,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_overflow,
  output logic                           ras_underflow
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [31:0]                    perf_stall_cnt,
  output logic [31:0]                    perf_flush_cnt
`endif
);

  localparam int CNT_W = $clog2(RAS_DEPTH+1);
  localparam int PTR_W = $clog2(RAS_DEPTH);

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [INST_W-1:0] id_inst_q, id_inst_d;
  logic [PC_W-1:0]   id_ppo_q, id_ppo_d;
  logic              id_valid_q, id_valid_d;
  logic [PTR_W-1:0]  ras_ptr_q, ras_ptr_d;
  logic [CNT_W-1:0]  ras_cnt_q, ras_cnt_d;
  logic              ras_ovf_q, ras_ovf_d;
  logic              ras_unf_q, ras_unf_d;
  logic [PC_W-1:0]   ras_mem_q [RAS_DEPTH];

  logic              act;
  logic              redirect;
  logic              ras_empty;
  logic              ras_full;
  logic [PTR_W-1:0]  top_idx;
  logic [PC_W-1:0]   ras_top;
  logic [PC_W-1:0]   pc_plus_one;
  logic [PC_W-1:0]   redirect_pc;
  logic              ras_wr_en;
  logic [PTR_W-1:0]  ras_wr_addr;

  assign act         = id_valid_q & ~stall;
  assign redirect    = act & (id_ret | id_call | id_jump | id_branch);
  assign ras_empty   = (ras_cnt_q == '0);
  assign ras_full    = (ras_cnt_q == CNT_W'(RAS_DEPTH));
  assign top_idx     = ras_ptr_q - PTR_W'(1);
  assign ras_top     = ras_mem_q[top_idx];
  assign pc_plus_one = pc_q + PC_W'(1);

  // Return wins over call/jump/branch; an empty stack returns to RESET_PC.
  always_comb begin
    redirect_pc = id_target;
    if (id_ret) redirect_pc = ras_empty ? RESET_PC : ras_top;
  end

  always_comb begin
    pc_d        = pc_q;
    id_inst_d   = id_inst_q;
    id_ppo_d    = id_ppo_q;
    id_valid_d  = id_valid_q;
    ras_ptr_d   = ras_ptr_q;
    ras_cnt_d   = ras_cnt_q;
    ras_ovf_d   = ras_ovf_q;
    ras_unf_d   = ras_unf_q;
    ras_wr_en   = 1'b0;
    ras_wr_addr = ras_ptr_q;

    if (!stall) begin
      if (redirect) begin
        pc_d       = redirect_pc;
        id_inst_d  = '0;
        id_ppo_d   = '0;
        id_valid_d = 1'b0;
      end else begin
        pc_d       = pc_plus_one;
        id_inst_d  = if_instruction;
        id_ppo_d   = pc_plus_one;
        id_valid_d = 1'b1;
      end
    end

    if (act) begin
      if (id_call && id_ret) begin
        if (ras_empty) begin
          // Nothing to swap with: degrade to a plain push.
          ras_wr_en = 1'b1;
          ras_ptr_d = ras_ptr_q + PTR_W'(1);
          ras_cnt_d = ras_cnt_q + CNT_W'(1);
          ras_unf_d = 1'b1;
        end else begin
          ras_wr_en   = 1'b1;
          ras_wr_addr = top_idx;
        end
      end else if (id_call) begin
        // Full stack wraps onto the oldest entry.
        ras_wr_en = 1'b1;
        ras_ptr_d = ras_ptr_q + PTR_W'(1);
        if (ras_full) ras_ovf_d = 1'b1;
        else          ras_cnt_d = ras_cnt_q + CNT_W'(1);
      end else if (id_ret) begin
        if (ras_empty) begin
          ras_unf_d = 1'b1;
        end else begin
          ras_ptr_d = top_idx;
          ras_cnt_d = ras_cnt_q - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      id_inst_q  <= '0;
      id_ppo_q   <= '0;
      id_valid_q <= 1'b0;
      ras_ptr_q  <= '0;
      ras_cnt_q  <= '0;
      ras_ovf_q  <= 1'b0;
      ras_unf_q  <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_inst_q  <= id_inst_d;
      id_ppo_q   <= id_ppo_d;
      id_valid_q <= id_valid_d;
      ras_ptr_q  <= ras_ptr_d;
      ras_cnt_q  <= ras_cnt_d;
      ras_ovf_q  <= ras_ovf_d;
      ras_unf_q  <= ras_unf_d;
    end
  end

  // Stack storage carries no reset; contents are meaningless until pushed.
  always_ff @(posedge clk) begin
    if (ras_wr_en) ras_mem_q[ras_wr_addr] <= id_ppo_q;
  end

  assign pc             = pc_q;
  assign id_instruction = id_inst_q;
  assign id_pc_plus_one = id_ppo_q;
  assign id_valid       = id_valid_q;
  assign flush          = redirect;
  assign ras_count      = ras_cnt_q;
  assign ras_overflow   = ras_ovf_q;
  assign ras_underflow  = ras_unf_q;

`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q + (stall    ? 32'd1 : 32'd0);
    perf_flush_d = perf_flush_q + (redirect ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule
